ram_arbiter: RTL

//  Two-master arbiter in front of the byte-lane data RAM (independent write and read ports, 1-cycle read latency).

---
 rtl/ram_arbiter_pkg.sv | 26 ++
 rtl/ram_arbiter_rr_arb2.sv | 65 ++++++
 rtl/ram_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_pkg
//  Purpose  : Shared master ids, read-strobe level and owner type for the
//             two-master byte-lane RAM arbiter.
//  Contents : ARB_M0 / ARB_M1 master ids, RD_ENABLE strobe level, owner_e.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_arbiter_pkg;

    // Master ids. Master 0 is the core load/store unit, master 1 is the
    // debug/loader port.
    localparam logic ARB_M0    = 1'b0;
    localparam logic ARB_M1    = 1'b1;

    // Active level of the RAM read strobe.
    localparam logic RD_ENABLE = 1'b1;

    // Owner of the read that is in flight towards the RAM.
    typedef enum logic {
        OWNER_M0 = ARB_M0,
        OWNER_M1 = ARB_M1
    } owner_e;

endpackage : ram_arbiter_pkg
`default_nettype wire

// File: rtl/ram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way request arbiter. Grants at most one requester per
//             cycle; grants are combinational and forced low in reset.
//  Config   : RAM_ARB_RR_EN defined   -> round-robin, last-granted pointer
//                                        flop; the other master wins the
//                                        next contended cycle.
//             RAM_ARB_RR_EN undefined -> fixed priority, requester 0 wins;
//                                        no pointer flop and no clock port.
//  Ports    : clk      in  1  clock (round-robin build only)
//             rst      in  1  synchronous active-high reset
//             req_i    in  2  request per master
//             gnt_o    out 2  one-hot (or zero) grant
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
`ifdef RAM_ARB_RR_EN
    input  logic       clk,
`endif
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef RAM_ARB_RR_EN
    // last_q: 0 = master 0 was granted last, 1 = master 1 was granted last.
    // Reset value 1 makes master 0 win the first contended cycle.
    logic last_q;
    logic last_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (!rst) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
            // Any grant, contended or not, moves the pointer.
            if (|gnt_o) begin
                last_d = gnt_o[1];
            end
        end
    end
`else
    always_comb begin
        gnt_o    = 2'b00;
        gnt_o[0] = req_i[0] & ~rst;
        gnt_o[1] = req_i[1] & ~req_i[0] & ~rst;
    end
`endif

endmodule : rr_arb2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Two-master arbiter in front of a byte-lane data RAM with
//             independent write and read ports and 1-cycle read latency.
//             Read and write ports are arbitrated independently, the
//             in-flight read is tracked and its data returned to the owner,
//             and a same-cycle write to the word being read is forwarded
//             into the returned data.
//  Config   : RAM_ARB_RR_EN defined -> round-robin per port, otherwise
//             fixed priority with master 0 winning contention.
//  Ports    : clk, rst                        clock, sync active-high reset
//             mN_req_i/we_i/be_i/addr_i/wdata_i  master N request fields
//             mN_gnt_o                        request accepted (combinational)
//             mN_rvalid_o/rdata_o             read return, cycle after grant
//             ram_wr_en_o/wr_addr_o/wr_data_o RAM write port
//             ram_rd_en_o/rd_addr_o           RAM read request
//             ram_rd_data_i                   RAM read data (1 cycle later)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,

    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,

    output logic [DATA_WIDTH/8-1:0] ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wr_data_o,
    output logic                    ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data_i
);

    localparam int NUM_LANES = DATA_WIDTH / 8;

    // ------------------------------------------------------------------
    // Port classification and arbitration
    // ------------------------------------------------------------------
    logic [1:0] w_rd_req;
    logic [1:0] w_wr_req;
    logic [1:0] w_rd_gnt;
    logic [1:0] w_wr_gnt;

    assign w_wr_req = {m1_req_i &  m1_we_i, m0_req_i &  m0_we_i};
    assign w_rd_req = {m1_req_i & ~m1_we_i, m0_req_i & ~m0_we_i};

    rr_arb2 u_rd_arb (
`ifdef RAM_ARB_RR_EN
        .clk   (clk),
`endif
        .rst   (rst),
        .req_i (w_rd_req),
        .gnt_o (w_rd_gnt)
    );

    rr_arb2 u_wr_arb (
`ifdef RAM_ARB_RR_EN
        .clk   (clk),
`endif
        .rst   (rst),
        .req_i (w_wr_req),
        .gnt_o (w_wr_gnt)
    );

    // A master is either a read or a write contender, never both, so at
    // most one of its two grant bits can be set.
    assign m0_gnt_o = w_rd_gnt[0] | w_wr_gnt[0];
    assign m1_gnt_o = w_rd_gnt[1] | w_wr_gnt[1];

    // ------------------------------------------------------------------
    // RAM write and read request muxes (zero when nothing is granted)
    // ------------------------------------------------------------------
    always_comb begin
        ram_wr_en_o   = '0;
        ram_wr_addr_o = '0;
        ram_wr_data_o = '0;
        if (w_wr_gnt[0]) begin
            ram_wr_en_o   = m0_be_i;
            ram_wr_addr_o = m0_addr_i;
            ram_wr_data_o = m0_wdata_i;
        end else if (w_wr_gnt[1]) begin
            ram_wr_en_o   = m1_be_i;
            ram_wr_addr_o = m1_addr_i;
            ram_wr_data_o = m1_wdata_i;
        end
    end

    always_comb begin
        ram_rd_en_o   = ~RD_ENABLE;
        ram_rd_addr_o = '0;
        if (w_rd_gnt[0]) begin
            ram_rd_en_o   = RD_ENABLE;
            ram_rd_addr_o = m0_addr_i;
        end else if (w_rd_gnt[1]) begin
            ram_rd_en_o   = RD_ENABLE;
            ram_rd_addr_o = m1_addr_i;
        end
    end

    // ------------------------------------------------------------------
    // Read tracking and collision forwarding
    // ------------------------------------------------------------------
    // Only the word index is compared: bits at and above RAM_ADDR_WIDTH
    // alias onto the same RAM word.
    logic w_collide;
    assign w_collide = (ram_rd_en_o == RD_ENABLE) && (|w_wr_gnt) &&
                       (ram_rd_addr_o[RAM_ADDR_WIDTH-1:2] ==
                        ram_wr_addr_o[RAM_ADDR_WIDTH-1:2]);

    logic                  rd_valid_q,  rd_valid_d;
    owner_e                rd_owner_q,  rd_owner_d;
    logic [NUM_LANES-1:0]  fwd_be_q,    fwd_be_d;
    logic [DATA_WIDTH-1:0] fwd_data_q,  fwd_data_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q,  m0_rdata_d;
    logic [DATA_WIDTH-1:0] m1_rdata_q,  m1_rdata_d;
    logic [DATA_WIDTH-1:0] w_rd_merged;
    logic                  w_m0_hit;
    logic                  w_m1_hit;

    // The RAM returns pre-write data on a same-cycle collision; lanes the
    // colliding write enabled are replaced with the written bytes.
    for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
        assign w_rd_merged[b*8 +: 8] = fwd_be_q[b] ? fwd_data_q[b*8 +: 8]
                                                   : ram_rd_data_i[b*8 +: 8];
    end

    assign w_m0_hit = rd_valid_q && (rd_owner_q == OWNER_M0);
    assign w_m1_hit = rd_valid_q && (rd_owner_q == OWNER_M1);

    always_comb begin
        rd_valid_d = (ram_rd_en_o == RD_ENABLE);
        rd_owner_d = w_rd_gnt[1] ? OWNER_M1 : OWNER_M0;
        fwd_be_d   = w_collide ? ram_wr_en_o : '0;
        fwd_data_d = ram_wr_data_o;
        m0_rdata_d = w_m0_hit ? w_rd_merged : m0_rdata_q;
        m1_rdata_d = w_m1_hit ? w_rd_merged : m1_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_owner_q <= OWNER_M0;
            fwd_be_q   <= '0;
            fwd_data_q <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_owner_q <= rd_owner_d;
            fwd_be_q   <= fwd_be_d;
            fwd_data_q <= fwd_data_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Reset is synchronous, so a read granted the cycle before reset is
    // still held in rd_valid_q while rst is high; the returns are masked
    // so that read is discarded and all outputs read zero during reset.
    assign m0_rvalid_o = w_m0_hit & ~rst;
    assign m1_rvalid_o = w_m1_hit & ~rst;
    assign m0_rdata_o  = rst ? '0 : (w_m0_hit ? w_rd_merged : m0_rdata_q);
    assign m1_rdata_o  = rst ? '0 : (w_m1_hit ? w_rd_merged : m1_rdata_q);

endmodule : ram_arbiter
`default_nettype wire
